// File: rtl/min_sad_select_if.sv
// min_sad_select_if: bundle between the SAD pipeline / search control and the
// minimum-SAD selector.
//   start        : one-cycle pulse, begin a new block search
//   mad_res      : SAD pipeline word {unused, sad[11:0], addr[7:0]}
//   busy         : selector is in FILL or SEARCH
//   done         : one-cycle pulse when a search completes
//   best_sad     : minimum SAD of the last completed search
//   best_addr    : candidate address paired with best_sad
//   compare_out  : {1'b0, best_sad, best_addr}
//   cand_cnt     : candidates consumed in the current search
//   early_thresh : (SAD_EARLY_TERM_EN only) early-termination SAD threshold
//   early_hit    : (SAD_EARLY_TERM_EN only) qualifies done as an early stop
// Optional feature macro: SAD_EARLY_TERM_EN.
// master = producer of start/mad_res; slave = the selector.
interface min_sad_select_if #(
  parameter int unsigned CW = 7
);
  logic          start;
  logic [20:0]   mad_res;
  logic          busy;
  logic          done;
  logic [11:0]   best_sad;
  logic [7:0]    best_addr;
  logic [20:0]   compare_out;
  logic [CW-1:0] cand_cnt;
`ifdef SAD_EARLY_TERM_EN
  logic [11:0]   early_thresh;
  logic          early_hit;

  modport master (
    output start, mad_res, early_thresh,
    input  busy, done, best_sad, best_addr, compare_out, cand_cnt, early_hit
  );
  modport slave (
    input  start, mad_res, early_thresh,
    output busy, done, best_sad, best_addr, compare_out, cand_cnt, early_hit
  );
`else
  modport master (
    output start, mad_res,
    input  busy, done, best_sad, best_addr, compare_out, cand_cnt
  );
  modport slave (
    input  start, mad_res,
    output busy, done, best_sad, best_addr, compare_out, cand_cnt
  );
`endif
endinterface

// File: rtl/min_sad_select.sv
// min_sad_select: tracks the minimum SAD over NUM_CAND consecutive result
// words from the 4x4 SAD pipeline and reports the best SAD/address pair.
// After a start pulse the first FILL_LAT words (pipeline fill) are skipped.
// Ports:
//   clk  : system clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : min_sad_select_if.slave (start, mad_res, busy, done, best_sad,
//          best_addr, compare_out, cand_cnt [, early_thresh, early_hit])
// Optional feature macro: SAD_EARLY_TERM_EN -- stop the search as soon as a
// sample's SAD is <= early_thresh and flag it with early_hit.
module min_sad_select #(
  parameter int unsigned NUM_CAND = 64,
  parameter int unsigned FILL_LAT = 5,
  parameter int unsigned CW       = 7
) (
  input logic             clk,
  input logic             rst,
  min_sad_select_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, SEARCH, DONE} state_t;

  localparam int unsigned FW = $clog2(FILL_LAT + 2);
  // With no pipeline fill a start goes straight to sampling.
  localparam state_t START_STATE = (FILL_LAT == 0) ? SEARCH : FILL;

  state_t        state;
  logic [FW-1:0] fill_cnt;
  logic [CW-1:0] cnt;
  logic [11:0]   work_sad;
  logic [7:0]    work_addr;
  logic [11:0]   best_sad_q;
  logic [7:0]    best_addr_q;
  logic          busy_q;
  logic          done_q;

  logic [11:0]   smp_sad;
  logic [7:0]    smp_addr;
  logic          hit;
  logic          take;
  logic          last_cand;
  logic [11:0]   nxt_sad;
  logic [7:0]    nxt_addr;
  logic          unused_msb;

  assign smp_sad    = bus.mad_res[19:8];
  assign smp_addr   = bus.mad_res[7:0];
  assign unused_msb = bus.mad_res[20];

`ifdef SAD_EARLY_TERM_EN
  logic early_hit_q;
  assign hit           = (smp_sad <= bus.early_thresh);
  assign bus.early_hit = early_hit_q;
`else
  assign hit = 1'b0;
`endif

  // cnt is zero exactly on the first SEARCH sample, which loads
  // unconditionally; later samples need a strictly smaller SAD.
  assign take      = (cnt == '0) || (smp_sad < work_sad) || hit;
  assign nxt_sad   = take ? smp_sad  : work_sad;
  assign nxt_addr  = take ? smp_addr : work_addr;
  assign last_cand = (cnt == CW'(NUM_CAND - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fill_cnt    <= '0;
      cnt         <= '0;
      work_sad    <= '1;
      work_addr   <= '0;
      best_sad_q  <= '1;
      best_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SAD_EARLY_TERM_EN
      early_hit_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SAD_EARLY_TERM_EN
      early_hit_q <= 1'b0;
`endif
      // A start in any state (re)launches a search. In DONE the done pulse
      // is already on the outputs this cycle, so it is not lost.
      if (bus.start) begin
        state     <= START_STATE;
        fill_cnt  <= '0;
        cnt       <= '0;
        work_sad  <= '1;
        work_addr <= '0;
        busy_q    <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          FILL: begin
            if (fill_cnt == FW'(FILL_LAT - 1)) begin
              state <= SEARCH;
              cnt   <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          SEARCH: begin
            work_sad  <= nxt_sad;
            work_addr <= nxt_addr;
            if (cnt != CW'(NUM_CAND)) cnt <= cnt + 1'b1;
            if (last_cand || hit) begin
              state       <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              best_sad_q  <= nxt_sad;
              best_addr_q <= nxt_addr;
`ifdef SAD_EARLY_TERM_EN
              early_hit_q <= hit;
`endif
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.best_sad    = best_sad_q;
  assign bus.best_addr   = best_addr_q;
  assign bus.compare_out = {1'b0, best_sad_q, best_addr_q};
  assign bus.cand_cnt    = cnt;

endmodule

// File: tb/tb_min_sad_select.sv
// tb_min_sad_select: directed scoreboard bench for min_sad_select.
module tb_min_sad_select;

  localparam int unsigned NUM_CAND = 64;
  localparam int unsigned FILL_LAT = 5;
  localparam int unsigned CW       = 7;

  typedef struct {
    logic [11:0] sad;
    logic [7:0]  addr;
    int unsigned cnt;
    int unsigned cyc;
    bit          hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned dones = 0;
  int unsigned exp_dones = 0;
  exp_t sb[$];

  logic [11:0] tab_sad [NUM_CAND];
  logic [7:0]  tab_addr[NUM_CAND];
  logic        tab_b20 [NUM_CAND];
  logic [11:0] thresh = 12'd0;
  bit          early_on = 1'b0;
  logic [11:0] cur_best = 12'hFFF;

  min_sad_select_if #(.CW(CW)) bus_if ();

  min_sad_select #(
    .NUM_CAND(NUM_CAND),
    .FILL_LAT(FILL_LAT),
    .CW      (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

`ifdef SAD_EARLY_TERM_EN
  assign bus_if.early_thresh = thresh;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_tab(input logic [11:0] s);
    for (int i = 0; i < NUM_CAND; i++) begin
      tab_sad[i]  = s;
      tab_addr[i] = 8'(i);
      tab_b20[i]  = 1'b0;
    end
  endtask

  // Drives a start at the current cycle, FILL_LAT fill words, then n
  // candidate words. When push is set the expected result goes to the
  // scoreboard.
  task automatic drive_search(input int unsigned n, input logic [11:0] fill_sad, input bit push);
    int unsigned p;
    int unsigned consumed;
    logic [11:0] es;
    logic [7:0]  ea;
    bit          eh;
    exp_t        e;
    consumed = NUM_CAND;
    es = 12'hFFF;
    ea = 8'h00;
    eh = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (i == 0 || tab_sad[i] < es) begin
        es = tab_sad[i];
        ea = tab_addr[i];
      end
      if (early_on && tab_sad[i] <= thresh) begin
        es = tab_sad[i];
        ea = tab_addr[i];
        eh = 1'b1;
        consumed = i + 1;
        break;
      end
    end
    p = cyc;
    if (push) begin
      e.sad  = es;
      e.addr = ea;
      e.cnt  = consumed;
      e.cyc  = p + FILL_LAT + consumed + 1;
      e.hit  = eh;
      sb.push_back(e);
      exp_dones++;
    end
    bus_if.start   = 1'b1;
    bus_if.mad_res = {1'b0, fill_sad, 8'hEE};
    for (int f = 0; f < int'(FILL_LAT); f++) begin
      tick();
      bus_if.start   = 1'b0;
      bus_if.mad_res = {1'b0, fill_sad, 8'hEE};
    end
    for (int i = 0; i < int'(n); i++) begin
      tick();
      bus_if.start   = 1'b0;
      bus_if.mad_res = {tab_b20[i], tab_sad[i], tab_addr[i]};
      if (i == 20) begin
        chk("mid_cand_cnt", 32'(bus_if.cand_cnt), (consumed < 20) ? consumed : 20);
        chk("mid_busy", 32'(bus_if.busy), 32'(20 < consumed));
        if (20 < consumed) chk("mid_best_stable", 32'(bus_if.best_sad), 32'(cur_best));
      end
    end
    if (push) cur_best = es;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus_if.done === 1'b1) begin
      exp_t e;
      dones++;
      n_checks++;
      assert (sb.size() != 0)
      else begin
        n_errors++;
        $error("FAIL unexpected_done observed=done_at_%0d expected=no_done", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("best_sad", 32'(bus_if.best_sad), 32'(e.sad));
        chk("best_addr", 32'(bus_if.best_addr), 32'(e.addr));
        chk("compare_out", 32'(bus_if.compare_out), {11'd0, 1'b0, e.sad, e.addr});
        chk("cand_cnt", 32'(bus_if.cand_cnt), e.cnt);
`ifdef SAD_EARLY_TERM_EN
        chk("early_hit", 32'(bus_if.early_hit), 32'(e.hit));
`endif
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus_if.start   = 1'b0;
    bus_if.mad_res = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_cand_cnt", 32'(bus_if.cand_cnt), 32'd0);
    chk("rst_best_sad", 32'(bus_if.best_sad), 32'hFFF);
    chk("rst_best_addr", 32'(bus_if.best_addr), 32'h00);
    chk("rst_compare_out", 32'(bus_if.compare_out), 32'h0FFF00);
    rst = 1'b0;
    repeat (20) tick();
    chk("idle_best_sad", 32'(bus_if.best_sad), 32'hFFF);
    chk("idle_compare_out", 32'(bus_if.compare_out), 32'h0FFF00);
    chk("idle_busy", 32'(bus_if.busy), 32'd0);

    // Basic ramp: sad=100+i, minimum at candidate 0.
    for (int i = 0; i < NUM_CAND; i++) begin
      tab_sad[i]  = 12'(100 + i);
      tab_addr[i] = 8'(i);
      tab_b20[i]  = 1'b0;
    end
    drive_search(NUM_CAND, 12'd0, 1'b1);
    tick();

    // Start lands on the DONE cycle of the ramp search. Tie case: the
    // earlier of two equal minima wins.
    fill_tab(12'd500);
    tab_sad[17] = 12'd3; tab_addr[17] = 8'h91;
    tab_sad[40] = 12'd3; tab_addr[40] = 8'h28;
    drive_search(NUM_CAND, 12'd0, 1'b1);
    tick();
    bus_if.mad_res = '0;
    repeat (4) tick();

    // Fill words carry sad=0 and must not be sampled.
    fill_tab(12'd50);
    drive_search(NUM_CAND, 12'd0, 1'b1);
    tick();
    bus_if.mad_res = '0;
    repeat (4) tick();

    // Asynchronous reset in the middle of a search.
    fill_tab(12'd1);
    drive_search(15, 12'd0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus_if.busy), 32'd0);
    chk("arst_cand_cnt", 32'(bus_if.cand_cnt), 32'd0);
    chk("arst_best_sad", 32'(bus_if.best_sad), 32'hFFF);
    chk("arst_done", 32'(bus_if.done), 32'd0);
    cur_best = 12'hFFF;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Restart after 24 candidates: the sad=7 of the aborted search is lost.
    fill_tab(12'd500);
    tab_sad[10] = 12'd7;
    drive_search(24, 12'd0, 1'b0);
    tick();
    fill_tab(12'd500);
    tab_sad[50] = 12'd9; tab_addr[50] = 8'hC3;
    drive_search(NUM_CAND, 12'd0, 1'b1);
    tick();
    bus_if.mad_res = '0;
    repeat (4) tick();

    // Random SADs (never zero), bit 20 random and ignored.
    for (int i = 0; i < NUM_CAND; i++) begin
      tab_sad[i]  = 12'($urandom_range(1, 4095));
      tab_addr[i] = 8'($urandom_range(0, 255));
      tab_b20[i]  = 1'($urandom_range(0, 1));
    end
    drive_search(NUM_CAND, 12'd0, 1'b1);
    tick();
    bus_if.mad_res = '0;
    repeat (4) tick();

`ifdef SAD_EARLY_TERM_EN
    // Candidate 12 is under the threshold: done at start+19, cand_cnt=13.
    thresh   = 12'd10;
    early_on = 1'b1;
    fill_tab(12'd200);
    tab_sad[12] = 12'd8;
    drive_search(NUM_CAND, 12'd0, 1'b1);
    tick();
    bus_if.mad_res = '0;
    repeat (4) tick();
    thresh   = 12'd0;
    early_on = 1'b0;
`endif

    repeat (80) tick();
    chk("sb_drained", sb.size(), 32'd0);
    chk("done_count", dones, exp_dones);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/min_sad_select.md
Name: min_sad_select

Overview:
- Downstream of the 4x4 SAD pipeline. Consumes its 21-bit result word every clock during a block search.
- Result word layout: bit 20 = 0, bits [19:8] = 12-bit SAD, bits [7:0] = candidate address.
- Skips the SAD pipeline fill after a start pulse, then tracks the minimum SAD over NUM_CAND consecutive candidates.
- Reports the best SAD/address pair as the block's motion vector result.

Parameters:
- NUM_CAND, 64, number of candidate positions per search (one per clock, matches 6-bit read address range)
- FILL_LAT, 5, clocks between start and the first valid result word (SAD pipeline depth)
- CW, 7, width of the candidate counter; must satisfy 2^CW > NUM_CAND

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin a new search
- mad_res  in  21  SAD pipeline output {0, sad[11:0], addr[7:0]}
- busy  out  1  high in FILL and SEARCH states
- done  out  1  one-cycle pulse when a search completes
- best_sad  out  12  minimum SAD of the last completed search
- best_addr  out  8  address paired with best_sad
- compare_out  out  21  {1'b0, best_sad, best_addr}
- cand_cnt  out  CW  candidates consumed in the current search

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, cand_cnt=0.
  - best_sad=12'hFFF, best_addr=8'h00, compare_out={1'b0,12'hFFF,8'h00}.
- FSM states IDLE, FILL, SEARCH, DONE:
  - IDLE: start -> FILL, fill counter=0.
  - FILL: counts FILL_LAT clocks and ignores mad_res. On the last fill clock -> SEARCH with cand_cnt=0. FILL_LAT=0 goes from IDLE straight to SEARCH.
  - SEARCH: samples mad_res every clock and increments cand_cnt. After sampling candidate NUM_CAND-1 -> DONE.
  - DONE: lasts exactly one clock with done=1, then -> IDLE. Outputs hold until the next search completes.
- Compare rule:
  - The working minimum is kept in internal registers (work_sad, work_addr).
  - The first SEARCH sample loads unconditionally.
  - Later samples replace the working pair only if sad < work_sad (strict). Ties keep the earlier candidate.
  - best_sad/best_addr/compare_out update only on entry to DONE, copied from the working pair including the final sample. They are stable throughout a search.
- Latency: done asserts FILL_LAT+NUM_CAND+1 clocks after the start cycle (FILL_LAT fill clocks, NUM_CAND sample clocks, one DONE-entry register).
- SAD is a 12-bit unsigned compare. mad_res[20] is ignored.
- start in FILL or SEARCH: restart. Return to FILL, clear the fill counter, cand_cnt and the working pair. The aborted search never pulses done.
- start in DONE: done still pulses that clock; the next state is FILL instead of IDLE.
- Async reset mid-search: all state returns to reset values immediately, with no done pulse.
- cand_cnt saturates at NUM_CAND and clears on the next start.

Optional Feature:
- Macro SAD_EARLY_TERM_EN.
- Defined:
  - Adds input early_thresh[11:0] and output early_hit (1 bit).
  - In SEARCH, when a sample's sad <= early_thresh, that sample is taken as the result and the FSM moves to DONE on the next edge, skipping the remaining candidates.
  - early_hit=1 accompanies that done pulse; early_hit=0 otherwise.
  - cand_cnt reflects the samples actually consumed.
- Undefined: the ports are absent and every search consumes all NUM_CAND candidates.

Test Plan:
- Reset then idle: rst pulse, no start for 20 clocks -> best_sad=12'hFFF, compare_out=21'h0FFF00, busy=0, done never asserts.
- Basic search (NUM_CAND=64, FILL_LAT=5): start at cycle 0, then feed sad=100+i, addr=i for candidate i -> done pulses once at cycle 70; best_sad=100, best_addr=8'h00, cand_cnt=64.
- Minimum in the middle plus a tie: sad=500 everywhere except candidates 17 and 40, both sad=3 (addr 8'h91, 8'h28) -> best_sad=3, best_addr=8'h91 (earlier candidate wins).
- Fill samples ignored: sad=0 during the 5 FILL clocks, then all candidates sad=50 -> best_sad=50, not 0.
- Restart mid-search: start, then a second start at cycle 30, with min sad=7 only before cycle 30 and min sad=9 after -> a single done at cycle 100 with best_sad=9.
- SAD_EARLY_TERM_EN, early_thresh=10: candidate 12 has sad=8, all others 200 -> done pulses at cycle 19 with early_hit=1, best_sad=8, cand_cnt=13.
